qlogic_sync_fifo: RTL

QLOGIC_SYNC_FIFO -- requirements
Module: qlogic_sync_fifo

---
 rtl/qlogic_fifo_pkg.sv | 16 +
 rtl/qlogic_fifo_ram.sv | 23 ++
 rtl/qlogic_sync_fifo.sv | 91 +++++++++
 3 files changed

// File: rtl/qlogic_fifo_pkg.sv
// Shared constants and width helpers for the qlogic synchronous FIFO.
// Optional error flags are enabled with QLOGIC_FIFO_ERR_FLAGS_EN.
package qlogic_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/qlogic_fifo_ram.sv
// FIFO storage: one write port, one synchronous read port, no reset.
// A read and write to the same address in one cycle returns the old word.
module qlogic_fifo_ram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/qlogic_sync_fifo.sv
// Single-clock FIFO with level, almost-full and registered read data.
// Define QLOGIC_FIFO_ERR_FLAGS_EN to add sticky OVF/UDF outputs.
module qlogic_sync_fifo
  import qlogic_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_MARGIN  = 2
) (
  input  logic                      QCK,
  input  logic                      RN,
  input  logic                      PUSH,
  input  logic [DATA_WIDTH-1:0]     DIN,
  input  logic                      POP,
  output logic [DATA_WIDTH-1:0]     DOUT,
  output logic                      EMPTY,
  output logic                      FULL,
  output logic                      ALMOST_FULL,
  output logic [lvl_w(DEPTH)-1:0]   LEVEL
`ifdef QLOGIC_FIFO_ERR_FLAGS_EN
  ,
  output logic                      OVF,
  output logic                      UDF
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam int LW = lvl_w(DEPTH);
  localparam logic [LW-1:0] AF_TH = LW'(DEPTH - AF_MARGIN);

  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic                  vld;
  logic                  wr;
  logic                  rd;
  logic [DATA_WIDTH-1:0] q;

  assign EMPTY = (wptr == rptr);
  assign FULL  = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                 (wptr[AW] != rptr[AW]);
  assign LEVEL = LW'(wptr - rptr);
  assign ALMOST_FULL = (LEVEL >= AF_TH);

  // A pop frees a slot in the same edge, so push is taken when full too
  assign wr = PUSH && (!FULL || POP);
  assign rd = POP && !EMPTY;

  always_ff @(posedge QCK or negedge RN) begin
    if (!RN) begin
      wptr <= '0;
      rptr <= '0;
      vld  <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) begin
        rptr <= rptr + 1'b1;
        vld  <= 1'b1;
      end
    end
  end

  // RAM has no reset; DOUT reads zero until the first post-reset read
  assign DOUT = vld ? q : '0;

  qlogic_fifo_ram #(
    .DW(DATA_WIDTH),
    .AW(AW)
  ) u_ram (
    .clk  (QCK),
    .we   (wr),
    .waddr(wptr[AW-1:0]),
    .wdata(DIN),
    .re   (rd),
    .raddr(rptr[AW-1:0]),
    .rdata(q)
  );

`ifdef QLOGIC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge QCK or negedge RN) begin
    if (!RN) begin
      OVF <= 1'b0;
      UDF <= 1'b0;
    end else begin
      if (PUSH && FULL && !POP) OVF <= 1'b1;
      if (POP && EMPTY)         UDF <= 1'b1;
    end
  end
`endif

endmodule
